// File: rtl/router_fifo_if.sv
// Handshake bundle between router_register, one output FIFO and its destination reader.
// Carries almost_full only when ROUTER_FIFO_ALMOST_FULL_EN is defined.
interface router_fifo_if #(
    parameter int DATA_W = 8
);
    logic              write_enb;
    logic              lfd_state;
    logic [DATA_W-1:0] data_in;
    logic              read_enb;
    logic [DATA_W-1:0] data_out;
    logic              full;
    logic              empty;
    logic              pkt_end;
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
    logic              almost_full;

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, full, empty, pkt_end, almost_full
    );
    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, full, empty, pkt_end, almost_full
    );
`else
    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, full, empty, pkt_end
    );
    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, full, empty, pkt_end
    );
`endif
endinterface

// File: rtl/router_fifo.sv
// Output-side packet FIFO of the 1x3 router; tracks packet boundaries from the header length.
// Optional almost_full flag is built when ROUTER_FIFO_ALMOST_FULL_EN is defined.
module router_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            soft_reset,
    router_fifo_if.slave    bus
);
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W:0]   r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic [5:0]        r_pkt_cnt;
    logic [DATA_W-1:0] r_data_out;
    logic              r_pkt_end;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_ok;
    logic              w_rd_ok;
    logic [DATA_W:0]   w_rd_word;
    logic [5:0]        w_hdr_len;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                       (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
    assign w_wr_ok   = bus.write_enb && !w_full;
    assign w_rd_ok   = bus.read_enb && !w_empty;
    assign w_rd_word = r_mem[r_rd_ptr[ADDR_W-1:0]];
    // Header byte carries the payload length in its upper six bits.
    assign w_hdr_len = w_rd_word[DATA_W-1:DATA_W-6];

    assign bus.data_out = r_data_out;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.pkt_end  = r_pkt_end;

`ifdef ROUTER_FIFO_ALMOST_FULL_EN
    localparam logic [ADDR_W:0] AF_LEVEL = (ADDR_W+1)'(DEPTH - 2);
    logic [ADDR_W:0] w_occupancy;

    assign w_occupancy     = r_wr_ptr - r_rd_ptr;
    assign bus.almost_full = (w_occupancy >= AF_LEVEL);
`endif

    // Storage array: contents survive both resets, only the pointers are cleared.
    always_ff @(posedge clk) begin
        if (w_wr_ok && !soft_reset) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    // Pointers, packet counter and registered read-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_cnt  <= 6'd0;
            r_data_out <= '0;
            r_pkt_end  <= 1'b0;
        end else if (soft_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pkt_cnt  <= 6'd0;
            r_data_out <= '0;
            r_pkt_end  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                r_data_out <= w_rd_word[DATA_W-1:0];
                if (w_rd_word[DATA_W]) begin
                    // Count covers the payload plus the trailing parity byte.
                    r_pkt_cnt <= w_hdr_len + 6'd1;
                    r_pkt_end <= 1'b0;
                end else if (r_pkt_cnt != 6'd0) begin
                    r_pkt_cnt <= r_pkt_cnt - 6'd1;
                    r_pkt_end <= (r_pkt_cnt == 6'd1);
                end else begin
                    r_pkt_end <= 1'b0;
                end
            end else begin
                r_pkt_end <= 1'b0;
                // Idle between packets returns the bus to zero; mid-packet it holds.
                if (r_pkt_cnt == 6'd0) begin
                    r_data_out <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: a scoreboard queue holds each accepted byte with its
// expected pkt_end flag, and reads pop and compare against it.
module tb_router_fifo;
    logic clk;
    logic rst;
    logic soft_reset;

    router_fifo_if #(.DATA_W(8)) bus ();

    router_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_reset (soft_reset),
        .bus        (bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One write cycle; the model only keeps it if the FIFO had room.
    task automatic wr(input logic lfd, input logic [7:0] d, input logic e);
        bus.write_enb = 1'b1;
        bus.lfd_state = lfd;
        bus.data_in   = d;
        step();
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
        if (q.size() < 16) q.push_back({d, e});
    endtask

    // One read cycle; data_out and pkt_end are checked one clock after read_enb is sampled.
    task automatic rd_chk(input string tag);
        exp_t x;
        bus.read_enb = 1'b1;
        step();
        bus.read_enb = 1'b0;
        if (q.size() == 0) begin
            chk({tag, "_sb_underrun"}, 32'd1, 32'd0);
        end else begin
            x = q.pop_front();
            chk({tag, "_data"}, 32'(bus.data_out), 32'(x.d));
            chk({tag, "_pkt_end"}, 32'(bus.pkt_end), 32'(x.e));
        end
    endtask

    initial begin
        exp_t x;
        rst           = 1'b1;
        soft_reset    = 1'b0;
        bus.write_enb = 1'b0;
        bus.lfd_state = 1'b0;
        bus.data_in   = 8'h00;
        bus.read_enb  = 1'b0;
        step();
        step();
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_data", 32'(bus.data_out), 32'd0);
        chk("rst_pkt_end", 32'(bus.pkt_end), 32'd0);
`ifdef ROUTER_FIFO_ALMOST_FULL_EN
        chk("rst_af", 32'(bus.almost_full), 32'd0);
`endif
        rst = 1'b0;
        step();

        // Basic: header 0x3A (14 payload bytes) + payload + parity fills all 16 entries
        wr(1'b1, 8'h3A, 1'b0);
        for (int i = 0; i < 14; i++) wr(1'b0, 8'(8'h10 + i), 1'b0);
        wr(1'b0, 8'hA5, 1'b1);
        chk("basic_full", 32'(bus.full), 32'd1);
        chk("basic_not_empty", 32'(bus.empty), 32'd0);

        // Overflow: extra 0xFF while full is dropped
        wr(1'b0, 8'hFF, 1'b0);
        chk("ovf_full", 32'(bus.full), 32'd1);
        chk("ovf_wr_ptr", 32'(dut.r_wr_ptr), 32'd16);
        for (int i = 0; i < 16; i++) rd_chk("basic_rd");
        chk("basic_empty_after", 32'(bus.empty), 32'd1);
        step();
        chk("basic_data_cleared", 32'(bus.data_out), 32'd0);

        // Underflow: reads while empty are ignored
        bus.read_enb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("udf_data", 32'(bus.data_out), 32'd0);
            chk("udf_empty", 32'(bus.empty), 32'd1);
            chk("udf_pkt_end", 32'(bus.pkt_end), 32'd0);
        end
        bus.read_enb = 1'b0;

        // Simultaneous read and write while full: read proceeds, write of 0xEE dropped
        wr(1'b1, 8'h3A, 1'b0);
        for (int i = 0; i < 14; i++) wr(1'b0, 8'(8'h40 + i), 1'b0);
        wr(1'b0, 8'h5C, 1'b1);
        chk("sim_full_before", 32'(bus.full), 32'd1);
        bus.write_enb = 1'b1;
        bus.data_in   = 8'hEE;
        bus.read_enb  = 1'b1;
        step();
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        x = q.pop_front();
        chk("sim_data", 32'(bus.data_out), 32'(x.d));
        chk("sim_full_after", 32'(bus.full), 32'd0);
        chk("sim_occupancy", 32'(5'(dut.r_wr_ptr - dut.r_rd_ptr)), 32'd15);
        for (int i = 0; i < 15; i++) rd_chk("sim_rd");
        chk("sim_empty_after", 32'(bus.empty), 32'd1);
        step();

        // Soft reset mid-packet
        wr(1'b1, 8'h09, 1'b0);
        wr(1'b0, 8'h55, 1'b0);
        rd_chk("srst_hdr");
        soft_reset = 1'b1;
        step();
        soft_reset = 1'b0;
        q.delete();
        chk("srst_empty", 32'(bus.empty), 32'd1);
        chk("srst_data", 32'(bus.data_out), 32'd0);
        chk("srst_pkt_end", 32'(bus.pkt_end), 32'd0);
        chk("srst_pkt_cnt", 32'(dut.r_pkt_cnt), 32'd0);
        wr(1'b1, 8'h05, 1'b0);
        wr(1'b0, 8'h66, 1'b0);
        wr(1'b0, 8'h77, 1'b1);
        for (int i = 0; i < 3; i++) rd_chk("srst_pkt2");
        chk("srst_pkt2_empty", 32'(bus.empty), 32'd1);
        step();

        // Asynchronous reset between clock edges, mid-read
        wr(1'b1, 8'h09, 1'b0);
        wr(1'b0, 8'h11, 1'b0);
        wr(1'b0, 8'h22, 1'b0);
        wr(1'b0, 8'h33, 1'b1);
        rd_chk("arst_rd");
        rd_chk("arst_rd");
        #3;
        rst = 1'b1;
        #1;
        chk("arst_data", 32'(bus.data_out), 32'd0);
        chk("arst_empty", 32'(bus.empty), 32'd1);
        chk("arst_pkt_end", 32'(bus.pkt_end), 32'd0);
        q.delete();
        step();
        rst = 1'b0;
        step();

`ifdef ROUTER_FIFO_ALMOST_FULL_EN
        for (int i = 0; i < 13; i++) wr(1'b0, 8'(i), 1'b0);
        chk("af_at_13", 32'(bus.almost_full), 32'd0);
        wr(1'b0, 8'h0D, 1'b0);
        chk("af_at_14", 32'(bus.almost_full), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
